// File: rtl/case_seq_pkg.sv
// Shared types and constants for the case-select sequencer and its FIFO.
package case_seq_pkg;

    localparam int          SEL_W_DEF   = 2;
    localparam int          HOLD_W_DEF  = 4;
    localparam int unsigned DEFAULT_SEL = 0;

    // Two-bit encoding on purpose: 2'b10 and 2'b11 are illegal and recover to IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01
    } state_e;

    typedef struct packed {
        logic [HOLD_W_DEF-1:0] hold;
        logic [SEL_W_DEF-1:0]  sel;
    } entry_t;

endpackage

// File: rtl/case_seq_fifo.sv
// Synchronous command FIFO. A newly written entry becomes poppable one cycle
// after the push, so empty_o reports only entries older than the last edge.
module case_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             push_q;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == {{(CNT_W-1){1'b0}}, push_q});
    assign push_ok_s  = push_i && !full_o;
    assign pop_ok_s   = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];

    // Occupancy next-state from the accepted push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers, occupancy and the just-pushed flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            push_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            push_q  <= push_ok_s;
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/case_sel_sequencer.sv
// Buffers select codes and presents one stable, registered select per
// transaction. Optional ILLEGAL_SEL_EN drops selects not set in LEGAL_MASK.
module case_sel_sequencer
    import case_seq_pkg::*;
#(
    parameter int                     SEL_W      = SEL_W_DEF,
    parameter int                     DEPTH      = 4,
    parameter int                     HOLD_W     = HOLD_W_DEF,
    parameter logic [(1<<SEL_W)-1:0]  LEGAL_MASK = 4'b0011
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic [HOLD_W-1:0] in_hold,
    output logic              out_valid,
    output logic [SEL_W-1:0]  out_x,
    input  logic              out_ack,
    output logic              err_pulse,
    output logic [7:0]        err_cnt
);

    state_e            state_q;
    logic              out_valid_q;
    logic [SEL_W-1:0]  out_x_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic              err_pulse_q;
    logic [7:0]        err_cnt_q;

    entry_t            push_entry_s;
    entry_t            pop_entry_s;
    logic              full_s;
    logic              empty_s;
    logic              pop_s;
    logic              legal_s;
    logic              load_s;
    logic              drop_s;
    logic              unused_mask_s;

    assign push_entry_s.sel  = in_sel;
    assign push_entry_s.hold = in_hold;
    assign in_ready          = !full_s;
    assign unused_mask_s     = ^LEGAL_MASK;

    case_seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (in_valid),
        .push_data_i (push_entry_s),
        .pop_i       (pop_s),
        .pop_data_o  (pop_entry_s),
        .full_o      (full_s),
        .empty_o     (empty_s)
    );

`ifdef ILLEGAL_SEL_EN
    assign legal_s = LEGAL_MASK[pop_entry_s.sel];
`else
    assign legal_s = 1'b1;
`endif

    // Pop only from IDLE or when the active transaction completes this edge.
    always_comb begin
        pop_s = 1'b0;
        case (state_q)
            IDLE:    pop_s = !empty_s;
            ACTIVE:  pop_s = !empty_s && (hold_cnt_q == {HOLD_W{1'b0}}) && out_ack;
            default: pop_s = 1'b0;
        endcase
    end

    assign load_s = pop_s && legal_s;
    assign drop_s = pop_s && !legal_s;

    // Transaction FSM with registered select, hold counter and error reporting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_x_q     <= SEL_W'(DEFAULT_SEL);
            hold_cnt_q  <= {HOLD_W{1'b0}};
            err_pulse_q <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            err_pulse_q <= drop_s;
            if (drop_s && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
            case (state_q)
                IDLE: begin
                    if (load_s) begin
                        out_x_q     <= pop_entry_s.sel;
                        hold_cnt_q  <= pop_entry_s.hold;
                        out_valid_q <= 1'b1;
                        state_q     <= ACTIVE;
                    end else begin
                        out_valid_q <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (hold_cnt_q != {HOLD_W{1'b0}}) begin
                        hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
                    end else if (out_ack) begin
                        // Back-to-back reload keeps out_valid high with no bubble.
                        if (load_s) begin
                            out_x_q     <= pop_entry_s.sel;
                            hold_cnt_q  <= pop_entry_s.hold;
                            out_valid_q <= 1'b1;
                        end else begin
                            out_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_case_sel_sequencer.sv
// Directed-vector bench for case_sel_sequencer; expectations follow the
// build (ILLEGAL_SEL_EN defined or not).
module tb_case_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_sel;
    logic [3:0] in_hold;
    logic       out_valid;
    logic [1:0] out_x;
    logic       out_ack;
    logic       err_pulse;
    logic [7:0] err_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    case_sel_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_hold   (in_hold),
        .out_valid (out_valid),
        .out_x     (out_x),
        .out_ack   (out_ack),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one command and wait (bounded) until it is taken at an edge.
    task automatic push_cmd(input logic [1:0] sel, input logic [3:0] hold);
        in_valid = 1'b1;
        in_sel   = sel;
        in_hold  = hold;
        for (int i = 0; i < 20 && !in_ready; i++) step();
        check_val("push_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [1:0] seq [6];
        int         k;
        int         hi_cnt;
        int         bad_x;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sel   = 2'd0;
        in_hold  = 4'd0;
        out_ack  = 1'b0;
        step();
        step();
        check_val("rst_valid", out_valid, 0);
        check_val("rst_x", out_x, 0);
        check_val("rst_ready", in_ready, 1);
        check_val("rst_errp", err_pulse, 0);
        check_val("rst_errc", err_cnt, 0);
        rst_n = 1'b1;
        step();

        // 1: basic latency, ack, out_x retained in IDLE
        push_cmd(2'd1, 4'd0);
        check_val("t1_lat_n", out_valid, 0);
        step();
        check_val("t1_lat_n1", out_valid, 0);
        step();
        check_val("t1_lat_n2", out_valid, 1);
        check_val("t1_x", out_x, 1);
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        check_val("t1_idle", out_valid, 0);
        check_val("t1_keep_x", out_x, 1);

        // 2: hold=3 with ack high -> exactly 4 valid cycles
        out_ack = 1'b1;
        push_cmd(2'd2, 4'd3);
        hi_cnt = 0;
        bad_x  = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) begin
                hi_cnt++;
                if (out_x != 2'd2) bad_x++;
            end
        end
        out_ack = 1'b0;
        check_val("t2_hold_len", hi_cnt, 4);
        check_val("t2_x_stable", bad_x, 0);

        // 3: fill (1 active + DEPTH queued), overflow push waits for first ack
`ifdef ILLEGAL_SEL_EN
        seq = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1};
`else
        seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
`endif
        for (int i = 0; i < 5; i++) push_cmd(seq[i], 4'd0);
        check_val("t3_full", in_ready, 0);
        check_val("t3_first_v", out_valid, 1);
        check_val("t3_first_x", out_x, seq[0]);
        in_valid = 1'b1;
        in_sel   = seq[5];
        in_hold  = 4'd0;
        for (int i = 0; i < 3; i++) step();
        check_val("t3_stall", in_ready, 0);
        check_val("t3_no_ack_x", out_x, seq[0]);
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        check_val("t3_after_ack", out_x, seq[1]);
        check_val("t3_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        out_ack  = 1'b1;
        k = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) begin
                k++;
                if (k < 6) check_val($sformatf("t3_order%0d", k), out_x, seq[k]);
            end
        end
        out_ack = 1'b0;
        check_val("t3_count", k, 5);

        // 4: three queued with ack high -> adjacent cycles, no bubble
        out_ack = 1'b1;
        push_cmd(2'd1, 4'd0);
        push_cmd(2'd0, 4'd0);
        push_cmd(2'd1, 4'd0);
        check_val("t4_v0", out_valid, 1);
        check_val("t4_x0", out_x, 1);
        step();
        check_val("t4_v1", out_valid, 1);
        check_val("t4_x1", out_x, 0);
        step();
        check_val("t4_v2", out_valid, 1);
        check_val("t4_x2", out_x, 1);
        step();
        check_val("t4_end", out_valid, 0);
        out_ack = 1'b0;

        // 5: illegal select handling (or forwarding without the feature)
        push_cmd(2'd3, 4'd0);
        push_cmd(2'd1, 4'd0);
        check_val("t5_pre_errp", err_pulse, 0);
        step();
`ifdef ILLEGAL_SEL_EN
        check_val("t5_errp", err_pulse, 1);
        check_val("t5_errc", err_cnt, 1);
        check_val("t5_drop_v", out_valid, 0);
        step();
        check_val("t5_errp_clr", err_pulse, 0);
        check_val("t5_v", out_valid, 1);
        check_val("t5_x", out_x, 1);
        check_val("t5_errc_hold", err_cnt, 1);
        out_ack = 1'b1;
        step();
`else
        check_val("t5_fwd_v", out_valid, 1);
        check_val("t5_fwd_x", out_x, 3);
        check_val("t5_errp0", err_pulse, 0);
        out_ack = 1'b1;
        step();
        check_val("t5_next_x", out_x, 1);
        check_val("t5_errc0", err_cnt, 0);
        step();
`endif
        out_ack = 1'b0;
        check_val("t5_idle", out_valid, 0);

        // 6: reset while ACTIVE with two queued entries
        push_cmd(2'd1, 4'd5);
        push_cmd(2'd0, 4'd5);
        push_cmd(2'd1, 4'd5);
        check_val("t6_active", out_valid, 1);
        rst_n = 1'b0;
        step();
        check_val("t6_rst_v", out_valid, 0);
        check_val("t6_rst_rdy", in_ready, 1);
        check_val("t6_rst_x", out_x, 0);
        check_val("t6_rst_errp", err_pulse, 0);
        check_val("t6_rst_errc", err_cnt, 0);
        rst_n = 1'b1;
        hi_cnt = 0;
        out_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid) hi_cnt++;
        end
        out_ack = 1'b0;
        check_val("t6_quiet", hi_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
